// File: rtl/alu_exec_pkg.sv
// Shared types for the alu_8 execute stage: opcode enum, Z80 register indices,
// FSM state encoding and the opcode legality check.
package alu_exec_pkg;

  localparam int DATA_W = 8;
  localparam int REG_N  = 8;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_ADC = 5'd1,
    OP_SUB = 5'd2,
    OP_SBC = 5'd3,
    OP_AND = 5'd4,
    OP_XOR = 5'd6,
    OP_OR  = 5'd7,
    OP_CP  = 5'd8,
    OP_INC = 5'd9,
    OP_DEC = 5'd10,
    OP_CPL = 5'd11,
    OP_RLC = 5'd14,
    OP_RRC = 5'd15,
    OP_TST = 5'd16
  } alu_op_e;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_F = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } exec_state_e;

  function automatic logic is_legal_op(input logic [4:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR,
      OP_CP, OP_INC, OP_DEC, OP_CPL, OP_RLC, OP_RRC, OP_TST: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_exec_stage_regfile.sv
// z80_regfile: 8x8 Z80 register file with two operand read ports, a debug read
// port, a writeback port (destination + F) and a lower-priority load port.
module z80_regfile
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        rd_a_idx,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [2:0]        rd_b_idx,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic [2:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wb_we,
  input  logic [2:0]        wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              f_we,
  input  logic [DATA_W-1:0] f_data,
  input  logic              ld_we,
  input  logic [2:0]        ld_idx,
  input  logic [DATA_W-1:0] ld_data
);

  logic [REG_N-1:0][DATA_W-1:0] regs_q;
  logic [REG_N-1:0][DATA_W-1:0] regs_d;

  assign rd_a_data = regs_q[rd_a_idx];
  assign rd_b_data = regs_q[rd_b_idx];
  assign dbg_data  = regs_q[dbg_idx];

  // Per-register write select: destination beats flag update beats load.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < REG_N; i++) begin
      if (wb_we && (wb_idx == 3'(i))) begin
        regs_d[i] = wb_data;
      end else if (f_we && (REG_F == 3'(i))) begin
        regs_d[i] = f_data;
      end else if (ld_we && (ld_idx == 3'(i))) begin
        regs_d[i] = ld_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Four-state execute stage around alu_8 (IDLE, READ, EXEC, WB) with a Z80 register file.
// Optional feature macro: ALU_EXEC_RETIRE_CNT_EN adds the 16-bit retire_cnt output.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int ALU_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_op,
  input  logic [2:0]           req_src_a,
  input  logic [2:0]           req_src_b,
  input  logic [ALU_WIDTH-1:0] req_imm,
  input  logic                 req_use_imm,
  input  logic [2:0]           req_dst,
  input  logic                 req_wb_en,
  input  logic                 req_flag_en,
  input  logic                 ld_en,
  input  logic [2:0]           ld_idx,
  input  logic [ALU_WIDTH-1:0] ld_data,
  input  logic [2:0]           dbg_sel,
  output logic [ALU_WIDTH-1:0] dbg_data,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic [4:0]           alu_opcode,
  input  logic [ALU_WIDTH-1:0] alu_out,
  input  logic [ALU_WIDTH-1:0] alu_status,
  output logic                 done,
  output logic                 err
`ifdef ALU_EXEC_RETIRE_CNT_EN
  ,
  output logic [15:0]          retire_cnt
`endif
);

  exec_state_e          state_q;
  logic [4:0]           op_q;
  logic [2:0]           src_a_q;
  logic [2:0]           src_b_q;
  logic [2:0]           dst_q;
  logic [ALU_WIDTH-1:0] imm_q;
  logic                 use_imm_q;
  logic                 wb_en_q;
  logic                 flag_en_q;
  logic [ALU_WIDTH-1:0] a_q;
  logic [ALU_WIDTH-1:0] b_q;
  logic [ALU_WIDTH-1:0] res_q;
  logic [ALU_WIDTH-1:0] flg_q;
  logic                 done_q;
  logic                 err_q;

  logic                 op_legal;
  logic                 wb_we;
  logic                 f_we;
  logic [ALU_WIDTH-1:0] rd_a_data;
  logic [ALU_WIDTH-1:0] rd_b_data;

  z80_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_idx  (src_a_q),
    .rd_a_data (rd_a_data),
    .rd_b_idx  (src_b_q),
    .rd_b_data (rd_b_data),
    .dbg_idx   (dbg_sel),
    .dbg_data  (dbg_data),
    .wb_we     (wb_we),
    .wb_idx    (dst_q),
    .wb_data   (res_q),
    .f_we      (f_we),
    .f_data    (flg_q),
    .ld_we     (ld_en),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data)
  );

  // Writeback strobes: only in WB and only for a legal opcode; TST never writes its destination.
  always_comb begin
    op_legal = is_legal_op(op_q);
    wb_we    = 1'b0;
    f_we     = 1'b0;
    if ((state_q == ST_WB) && op_legal) begin
      wb_we = wb_en_q && (op_q != OP_TST);
      f_we  = flag_en_q;
    end else begin
      wb_we = 1'b0;
      f_we  = 1'b0;
    end
  end

  // Stage FSM with request latching, operand capture, result capture and retire pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 5'd0;
      src_a_q   <= 3'd0;
      src_b_q   <= 3'd0;
      dst_q     <= 3'd0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      wb_en_q   <= 1'b0;
      flag_en_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            src_a_q   <= req_src_a;
            src_b_q   <= req_src_b;
            dst_q     <= req_dst;
            imm_q     <= req_imm;
            use_imm_q <= req_use_imm;
            wb_en_q   <= req_wb_en;
            flag_en_q <= req_flag_en;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          a_q     <= rd_a_data;
          b_q     <= use_imm_q ? imm_q : rd_b_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_out;
          flg_q   <= alu_status;
          state_q <= ST_WB;
        end
        ST_WB: begin
          done_q  <= 1'b1;
          err_q   <= ~op_legal;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef ALU_EXEC_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;
  logic [15:0] retire_cnt_d;

  // Count every retirement, legal or not; wraps naturally at 16 bits.
  always_comb begin
    if (state_q == ST_WB) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Retire counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 16'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Multi-cycle execute stage wrapped around `alu_8`. It accepts one ALU instruction per handshake, reads operands from an internal 8-entry Z80 register file, and drives `alu_8` with `a`, `b` and `opcode`. It then captures `out` and `status_flag`, writing the result to the destination register and the flags to F. It sits between the instruction decoder (upstream) and `alu_8` (downstream).

## Interface
- `ALU_WIDTH`, default 8: datapath width. Only 8 is supported.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: instruction request present.
- `req_ready` out 1: stage can accept a request.
- `req_op` in 5: `alu_8` opcode.
- `req_src_a` in 3: register index for operand a.
- `req_src_b` in 3: register index for operand b.
- `req_imm` in 8: immediate value for operand b.
- `req_use_imm` in 1: when 1, operand b is `req_imm` instead of the register.
- `req_dst` in 3: destination register index.
- `req_wb_en` in 1: result writeback enable.
- `req_flag_en` in 1: flag update enable.
- `ld_en` in 1: direct register load strobe.
- `ld_idx` in 3: register index for the direct load.
- `ld_data` in 8: data for the direct load.
- `dbg_sel` in 3: register index for the debug read.
- `dbg_data` out 8: combinational read of register `dbg_sel`.
- `alu_a` out 8: operand a to `alu_8`.
- `alu_b` out 8: operand b to `alu_8`.
- `alu_opcode` out 5: opcode to `alu_8`.
- `alu_out` in 8: result from `alu_8`.
- `alu_status` in 8: `status_flag` from `alu_8`.
- `done` out 1: one-cycle pulse when an instruction retires.
- `err` out 1: one-cycle pulse when an illegal opcode retires.

## Operation
- Register indices: B=0, C=1, D=2, E=3, H=4, L=5, F=6, A=7.
- Legal opcodes: 0–4, 6–11, 14, 15, 16. Opcodes 5, 12, 13 and 17–31 are illegal.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE→READ on `req_valid & req_ready`. The request fields are latched.
  - READ→EXEC unconditionally. Operand a and operand b (register or immediate) are latched into `a_q` and `b_q`.
  - EXEC→WB unconditionally. `alu_out` is captured in `res_q` and `alu_status` in `flg_q`.
  - WB→IDLE unconditionally.
- `req_ready` = (state == IDLE).
- `alu_a`, `alu_b` and `alu_opcode` are driven from `a_q`, `b_q` and `op_q`. They hold their values outside EXEC.
- WB with a legal opcode:
  - If `wb_en` is set and the opcode is not 16, the destination register is written with `res_q`.
  - If `flag_en` is set, F is written with `flg_q`.
  - Opcode 16 (test) never writes the destination.
  - When the destination is F and both writes occur, the destination write wins over the flag update.
- WB with an illegal opcode: no register or F write, and `err` pulses together with `done`.
- Load port: `ld_en` writes `ld_data` to register `ld_idx` in any state. If it targets the same register as a WB write in the same cycle, the WB write wins.

## Timing
- Handshake accepted at edge N. Operands are read at N+1, the ALU result is captured at N+2, and the writeback plus `done` pulse occur at N+3.
- `req_ready` is high again in the cycle after N+3, so the throughput is one instruction per 4 cycles.
- Register file reads in READ see any write committed at or before that edge. Reads are not forwarded from the same-cycle load port.
- Reset values:
  - All registers, F, `a_q`, `b_q`, `op_q`, `res_q` and `flg_q` are 0.
  - `alu_a`, `alu_b` and `alu_opcode` are 0.
  - `done` and `err` are 0.
  - The state is IDLE, so `req_ready` is 1 once reset is released.
- Reset asserted mid-operation aborts the instruction immediately. Nothing is written, and `done` does not pulse.
- `dbg_data` reflects a write in the cycle after the write edge.

## Configuration
- `ALU_EXEC_RETIRE_CNT_EN` defined:
  - Adds output port `retire_cnt` (16 bits) and its counter, reset to 0.
  - The counter increments on every `done` pulse, including illegal-opcode retirements, and wraps from 0xFFFF to 0x0000.
- `ALU_EXEC_RETIRE_CNT_EN` undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package `alu_exec_pkg` holds:
  - the `alu_op_e` enum of opcode values;
  - the register-index constants (`REG_B` … `REG_A`, `REG_F`);
  - the `exec_state_e` FSM enum;
  - an `is_legal_op()` function.
- Sub-module `z80_regfile` provides the 8×8 register file:
  - async reset;
  - two combinational read ports plus the debug port;
  - two write ports, with the WB port taking priority over the load port.
- The test bench instantiates `alu_exec_stage` connected to the real `alu_8`.

## Test plan
- Load A=0x07 and B=0x07, then issue ADD (`dst`=A, `src_a`=A, `src_b`=B, `wb_en`, `flag_en`) → `done` at N+3, A=0x0E, F equals `alu_8` `status_flag` for 7+7.
- Load A=0xFF, then issue ADD with immediate 0x01 → A=0x00, F equals the `alu_8` flags for 0xFF+0x01.
- Load A=0x80, then issue SUB with immediate 0x01 and `wb_en` clear → A stays 0x80, F is updated with the `alu_8` flags for 0x80−0x01.
- Issue opcode 5 with `dst`=B → `err` and `done` pulse together, B and F are unchanged, and `req_ready` returns the following cycle.
- Hold `req_valid` high for two ADD requests → the second is accepted exactly 4 cycles after the first. With `ALU_EXEC_RETIRE_CNT_EN` defined, `retire_cnt`=2.
- Assert `rst_n` low during EXEC of a write to C=0x55 → C=0x00, no `done` pulse, `req_ready`=1 after reset release.
